// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ valid/ready byte producers.
// Define UART_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  input  logic                 tx_complete,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {
    StResync,
    StIdle,
    StWaitLow,
    StWaitHigh
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 tx_send_q, tx_send_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [IDW-1:0]       grant_id_q, grant_id_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [IDW-1:0]       winner;
  logic [7:0]           winner_data;

`ifndef UART_ARB_FIXED_PRIO_EN
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
`endif

  // Winner search. Round-robin scans indices >= rr_ptr first, then wraps to the low ones;
  // fixed priority uses only the second (lowest-index) pass.
  always_comb begin
    found       = 1'b0;
    winner      = '0;
    winner_data = '0;
`ifndef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i] && (IDW'(i) >= rr_ptr_q)) begin
        found       = 1'b1;
        winner      = IDW'(i);
        winner_data = req_data[8*i +: 8];
      end
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req_valid[i]) begin
        found       = 1'b1;
        winner      = IDW'(i);
        winner_data = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    tx_send_d   = 1'b0;
    tx_data_d   = tx_data_q;
    grant_id_d  = grant_id_q;
    busy_d      = busy_q;
`ifndef UART_ARB_FIXED_PRIO_EN
    rr_ptr_d    = rr_ptr_q;
`endif

    unique case (state_q)
      // Transmitter has no reset: wait for it to report idle before issuing anything.
      StResync: begin
        if (tx_complete) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      StIdle: begin
        if (found) begin
          state_d     = StWaitLow;
          tx_send_d   = 1'b1;
          tx_data_d   = winner_data;
          req_ready_d = NUM_REQ'(1) << winner;
          grant_id_d  = winner;
          busy_d      = 1'b1;
`ifndef UART_ARB_FIXED_PRIO_EN
          rr_ptr_d    = (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + IDW'(1);
`endif
        end
      end
      // No timeout: slow transmitters may take a few cycles to drop complete.
      StWaitLow: begin
        if (!tx_complete) begin
          state_d = StWaitHigh;
        end
      end
      StWaitHigh: begin
        if (tx_complete) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StResync;
      req_ready_q <= '0;
      tx_send_q   <= 1'b0;
      tx_data_q   <= 8'h00;
      grant_id_q  <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      tx_send_q   <= tx_send_d;
      tx_data_q   <= tx_data_d;
      grant_id_q  <= grant_id_d;
      busy_q      <= busy_d;
    end
  end

`ifndef UART_ARB_FIXED_PRIO_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  assign req_ready = req_ready_q;
  assign tx_send   = tx_send_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(req_ready));
  a_send_with_ready: assert property (@(posedge clock) disable iff (!reset_n)
    tx_send == (req_ready != '0));
  a_grant_range: assert property (@(posedge clock) disable iff (!reset_n)
    32'(grant_id) < NUM_REQ);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: behavioural arbiter model, per-cycle output compare,
// a model transmitter with random frame lengths, and directed scenarios with literal checks.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           tx_send;
  logic [7:0]     tx_data;
  logic           tx_complete;
  logic [1:0]     grant_id;
  logic           busy;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_send     (tx_send),
    .tx_data     (tx_data),
    .tx_complete (tx_complete),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           m_free;      // arbiter may grant at the next edge
  bit           m_need_low;  // a byte was sent, transmitter has not yet dropped complete
  int           m_ptr;
  int           m_w;
  logic [N-1:0] e_ready;
  bit           e_send;
  logic [7:0]   e_data;
  int           e_gid;
  bit           e_busy;
  int           grant_log[$];

  function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_free = 0; m_need_low = 0; m_ptr = 0;
      e_ready = '0; e_send = 0; e_data = 8'h00; e_gid = 0; e_busy = 1;
    end else begin
      e_ready = '0;
      e_send  = 0;
      if (m_free) begin
        m_w = pick(req_valid, m_ptr);
        if (m_w >= 0) begin
          e_send = 1; e_ready[m_w] = 1'b1; e_data = req_data[8*m_w +: 8]; e_gid = m_w;
          e_busy = 1; m_free = 0; m_need_low = 1; m_ptr = (m_w + 1) % N;
          grant_log.push_back(m_w);
        end
      end else if (m_need_low) begin
        if (!tx_complete) m_need_low = 0;
      end else if (tx_complete) begin
        m_free = 1; e_busy = 0;
      end
    end
  end

  always @(posedge clock) begin
    #1;
    chk("tx_send", 32'(tx_send), 32'(e_send));
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("tx_data", 32'(tx_data), 32'(e_data));
    chk("grant_id", 32'(grant_id), 32'(e_gid));
    chk("busy", 32'(busy), 32'(e_busy));
  end

  // ---------------- model transmitter ----------------
  bit hold_low = 1;
  bit rand_frame = 0;
  int frame_len = 10;
  int t_drop = 0;
  int t_low = 0;

  always @(negedge clock) begin
    if (hold_low) begin
      tx_complete = 1'b0;
    end else begin
      if (tx_send) begin
        t_drop = $urandom_range(0, 2);
        t_low  = rand_frame ? $urandom_range(1, 12) : frame_len;
      end
      if (t_drop > 0) t_drop--;
      else if (t_low > 0) begin
        tx_complete = 1'b0;
        t_low--;
      end else tx_complete = 1'b1;
    end
  end

  // ---------------- requesters ----------------
  int reload_left[N];

  task automatic drive_reqs(input bit new_en, input bit rand_reload);
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        if (rand_reload ? ($urandom_range(0, 1) == 1) : (reload_left[i] > 0)) begin
          if (!rand_reload) reload_left[i]--;
          req_data[8*i +: 8] = 8'($urandom);
        end else req_valid[i] = 1'b0;
      end else if (new_en && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic clear_reload();
    for (int i = 0; i < N; i++) reload_left[i] = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clock); #2 reset_n = 1'b0;
    @(posedge clock); #2 reset_n = 1'b1;
    grant_log.delete();
  endtask

  task automatic run_until_grants(input int n, input int budget, input string name);
    int k = 0;
    while (grant_log.size() < n && k < budget) begin
      @(negedge clock); drive_reqs(0, 0); k++;
    end
    chk(name, 32'(grant_log.size() >= n), 32'd1);
  endtask

  task automatic drain(input string name);
    int k = 0;
    clear_reload();
    while ((req_valid != '0 || busy) && k < 600) begin
      @(negedge clock); drive_reqs(0, 0); k++;
    end
    chk(name, 32'(req_valid == '0 && !busy), 32'd1);
  endtask

  int exp_fair[6];
  int exp_reassert[3];

  initial begin
`ifdef UART_ARB_FIXED_PRIO_EN
    exp_fair     = '{0, 0, 0, 0, 0, 0};
    exp_reassert = '{0, 0, 1};
`else
    exp_fair     = '{0, 1, 2, 3, 0, 1};
    exp_reassert = '{0, 1, 0};
`endif
    req_valid   = '0;
    req_data    = '0;
    tx_complete = 1'b0;
    clear_reload();

    // Reset release with transmitter complete held low, single request pending.
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    req_valid = 4'b0100;
    req_data  = 32'h3C5A_1E77;
    req_data[23:16] = 8'hA5;
    repeat (20) begin
      @(negedge clock);
      chk("hold_no_send", 32'(tx_send), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    @(posedge clock); #2 hold_low = 0;
    @(negedge clock);
    @(negedge clock);
    chk("resync_busy_low", 32'(busy), 32'd0);
    chk("resync_no_send", 32'(tx_send), 32'd0);
    @(negedge clock);
    chk("single_send", 32'(tx_send), 32'd1);
    chk("single_ready", 32'(req_ready), 32'h4);
    chk("single_data", 32'(tx_data), 32'hA5);
    chk("single_gid", 32'(grant_id), 32'd2);
    chk("single_model_gid", 32'(e_gid), 32'd2);
    req_valid[2] = 1'b0;
    drain("single_drain");

    // All four continuously valid: fairness order.
    pulse_reset();
    for (int i = 0; i < N; i++) reload_left[i] = 100;
    req_valid = 4'hF;
    req_data  = 32'($urandom);
    run_until_grants(6, 300, "fair_grants");
    for (int i = 0; i < 6; i++)
      if (i < grant_log.size()) chk($sformatf("fair_order_%0d", i), 32'(grant_log[i]), 32'(exp_fair[i]));
    drain("fair_drain");

    // Requester 0 re-presents right after its ready while requester 1 waits.
    pulse_reset();
    clear_reload();
    reload_left[0] = 1;
    req_valid = 4'b0011;
    req_data  = 32'($urandom);
    run_until_grants(3, 300, "reassert_grants");
    for (int i = 0; i < 3; i++)
      if (i < grant_log.size())
        chk($sformatf("reassert_order_%0d", i), 32'(grant_log[i]), 32'(exp_reassert[i]));
    drain("reassert_drain");

    // Reset mid-frame while waiting for complete to rise.
    pulse_reset();
    clear_reload();
    frame_len = 10;
    req_valid = 4'b0011;
    req_data  = 32'($urandom);
    run_until_grants(1, 100, "rst_first_grant");
    begin
      int k = 0;
      while (tx_complete !== 1'b0 && k < 20) begin
        @(negedge clock); drive_reqs(0, 0); k++;
      end
      chk("rst_tx_low_seen", 32'(tx_complete), 32'd0);
    end
    repeat (2) begin @(negedge clock); drive_reqs(0, 0); end
    @(posedge clock); #2 reset_n = 1'b0; hold_low = 1;
    #1;
    chk("rst_async_send", 32'(tx_send), 32'd0);
    chk("rst_async_ready", 32'(req_ready), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd1);
    chk("rst_async_gid", 32'(grant_id), 32'd0);
    @(posedge clock); #2 reset_n = 1'b1;
    grant_log.delete();
    repeat (5) begin
      @(negedge clock); drive_reqs(0, 0);
      chk("rst_hold_busy", 32'(busy), 32'd1);
      chk("rst_hold_no_send", 32'(tx_send), 32'd0);
    end
    @(posedge clock); #2 hold_low = 0;
    run_until_grants(1, 100, "rst_regrant");
    if (grant_log.size() > 0) chk("rst_regrant_id", 32'(grant_log[0]), 32'd1);
    drain("rst_drain");

    // Randomized traffic with random frame lengths and occasional resets.
    rand_frame = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      drive_reqs(1, 1);
      if ($urandom_range(0, 999) == 0) pulse_reset();
    end
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter between up to eight byte producers (console, debug dump, status reporter) by round-robin arbitration. Each requester uses a valid/ready handshake. The arbiter drives the transmitter's single-cycle `send` strobe and 8-bit data input, and tracks the transmitter's `complete` flag so that only one byte is in flight at a time. It sits between the requester logic and the transmitter in the top-level UART subsystem.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- IDW, $clog2(NUM_REQ), width of grant_id (derived, not overridden)

- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  bit i: requester i holds a byte
- req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot, one-cycle pulse: byte of requester i accepted
- tx_send  out  1  one-cycle strobe to the transmitter
- tx_data  out  8  byte to the transmitter; stable from tx_send until the transfer ends
- tx_complete  in  1  transmitter idle flag; low while a frame is in progress
- grant_id  out  IDW  index of the last granted requester
- busy  out  1  high from grant until the transmitter reports done

## Operation
- Reset values: req_ready=0, tx_send=0, tx_data=8'h00, grant_id=0, busy=1, state=RESYNC, rr_ptr=0.
- The transmitter has no reset. After reset, RESYNC waits until tx_complete=1, then moves to IDLE with busy<=0.
- IDLE: if any req_valid bit is set, select a winner by searching from rr_ptr upward, modulo NUM_REQ. On the next edge:
  - tx_data<=winner byte, tx_send<=1, req_ready[winner]<=1, grant_id<=winner, busy<=1
  - rr_ptr<=(winner+1) mod NUM_REQ
  - state<=WAIT_LOW
- WAIT_LOW: tx_send and req_ready return to 0 after one cycle. Stay until tx_complete=0, then go to WAIT_HIGH.
- WAIT_HIGH: stay until tx_complete=1, then go to IDLE with busy<=0.
- With no req_valid in IDLE: state, rr_ptr and the outputs hold.
- Requester rules:
  - req_valid and req_data must hold until req_ready.
  - Dropping req_valid before req_ready is a protocol violation; the outcome is undefined and gets no assertion.
  - A requester may present its next byte in the cycle after its req_ready.
- Valid requests are served only in IDLE, at most one byte per frame.

## Timing
- Grant latency: 1 cycle. req_valid seen in IDLE at edge k gives tx_send=1 and req_ready=1 during cycle k+1.
- tx_complete must fall within some finite number of cycles after tx_send. Transmitters that take 1-2 cycles to drop complete are tolerated because WAIT_LOW has no timeout.
- Back-to-back transfers: the next grant occurs 1 cycle after the IDLE entry that follows tx_complete rising. Minimum spacing is frame time + 2 cycles.
- Round-robin fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0.
- A requester first seen valid while busy competes at the next IDLE; no byte is lost.
- Reset asserted mid-transfer: all outputs go to reset values immediately (asynchronously). No new tx_send is issued until tx_complete=1 is observed.
- NUM_REQ not a power of two: rr_ptr wraps from NUM_REQ-1 to 0, and indices ≥ NUM_REQ are never granted.

## Configuration
- UART_ARB_FIXED_PRIO_EN
  - Defined: fixed priority; the lowest set index of req_valid always wins. rr_ptr is not implemented and grant_id still reports the winner.
  - Undefined (default): round-robin as described above.

## Test plan
- Reset with tx_complete held 0 for 20 cycles, then 1 -> no tx_send during hold; busy=1 until 1 cycle after tx_complete rises.
- Single request: req_valid=4'b0100, req_data[23:16]=8'hA5 -> the next cycle shows tx_send=1, req_ready=4'b0100, tx_data=8'hA5, grant_id=2.
- All four requesters valid continuously, model transmitter (complete low 2 cycles after send, frame 10 cycles) -> grants in order 0,1,2,3,0,1; exactly one tx_send per frame.
- With UART_ARB_FIXED_PRIO_EN and req_valid=4'b1010 held -> requester 1 always granted; requester 3 is granted only after requester 1 drops valid.
- reset_n pulsed low during WAIT_HIGH -> tx_send/req_ready/busy/grant_id at reset values in the same cycle; the arbiter resumes only after tx_complete=1; the pending requester is then re-granted.
- Requester 0 re-asserts valid in the cycle after its req_ready while requester 1 is valid -> requester 1 is granted next (round-robin).
